kt_cmd_responder: RTL and testbench

//  Knight's Tour command processor and response generator. Receives 16-bit commands

---
 rtl/kt_cmd_responder.sv | 168 ++++++++++++++++
 tb/tb_kt_cmd_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kt_cmd_responder.sv
// Knight's Tour command processor: decodes UART commands, starts the cal/move/tour
// engines and returns status bytes (A5 complete, 5A intermediate, RESP_ERR on failure).
module kt_cmd_responder #(
    parameter int               TMO_W    = 20,
    parameter logic [TMO_W-1:0] TMO_CLKS = 20'hFFFFF,
    parameter logic [7:0]       RESP_ERR = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        mv_go,
    output logic [7:0]  mv_hdng,
    output logic [3:0]  mv_cnt,
    output logic        fanfare,
    input  logic        mv_done,
    output logic        tour_go,
    output logic [2:0]  tour_x,
    output logic [2:0]  tour_y,
    input  logic        tour_step,
    input  logic        tour_done,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic        drop_err
);
    typedef enum logic [2:0] {
        IDLE, DISPATCH, WAIT_CAL, WAIT_MV, WAIT_TOUR, SEND, WAIT_SENT
    } state_t;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_STEP = 8'h5A;

    state_t           state, state_nxt;
    logic [15:0]      cmd_hold;
    logic [3:0]       opcode;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             waiting;
    logic             more, more_nxt;
    logic [7:0]       resp_nxt;
    logic             accept, is_cal, is_mv, is_tour;

    assign opcode  = cmd_hold[15:12];
    assign accept  = (state == IDLE) && cmd_rdy;
    assign is_cal  = (state == DISPATCH) && (opcode == 4'h0);
    assign is_mv   = (state == DISPATCH) && ((opcode == 4'h2) || (opcode == 4'h3));
    assign is_tour = (state == DISPATCH) && (opcode == 4'h4);
    assign waiting = (state == WAIT_CAL) || (state == WAIT_MV) || (state == WAIT_TOUR);
    // tmo_hit fires on the last allowed wait cycle so the error goes out TMO_CLKS after the go pulse
    assign tmo_hit = (tmo_cnt == TMO_CLKS - 1'b1);

    always_comb begin
        state_nxt = state;
        resp_nxt  = resp;
        more_nxt  = more;
        case (state)
            IDLE: begin
                if (cmd_rdy) state_nxt = DISPATCH;
            end
            DISPATCH: begin
                if (is_cal)       state_nxt = WAIT_CAL;
                else if (is_mv)   state_nxt = WAIT_MV;
                else if (is_tour) state_nxt = WAIT_TOUR;
                else begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_ERR;
                    more_nxt  = 1'b0;
                end
            end
            WAIT_CAL: begin
                if (cal_done) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_DONE;
                    more_nxt  = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_ERR;
                    more_nxt  = 1'b0;
                end
            end
            WAIT_MV: begin
                if (mv_done) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_DONE;
                    more_nxt  = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_ERR;
                    more_nxt  = 1'b0;
                end
            end
            WAIT_TOUR: begin
                // tour_done outranks a simultaneous tour_step
                if (tour_done) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_DONE;
                    more_nxt  = 1'b0;
                end else if (tour_step) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_STEP;
                    more_nxt  = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = SEND;
                    resp_nxt  = RESP_ERR;
                    more_nxt  = 1'b0;
                end
            end
            SEND: begin
                state_nxt = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (resp_sent) state_nxt = more ? WAIT_TOUR : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) cmd_hold <= cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            more        <= 1'b0;
            tmo_cnt     <= '0;
            clr_cmd_rdy <= 1'b0;
            strt_cal    <= 1'b0;
            mv_go       <= 1'b0;
            tour_go     <= 1'b0;
            mv_hdng     <= '0;
            mv_cnt      <= '0;
            fanfare     <= 1'b0;
            tour_x      <= '0;
            tour_y      <= '0;
            resp        <= '0;
            send_resp   <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            more        <= more_nxt;
            resp        <= resp_nxt;
            send_resp   <= (state_nxt == SEND);
            clr_cmd_rdy <= accept;
            strt_cal    <= is_cal;
            mv_go       <= is_mv;
            tour_go     <= is_tour;
            tmo_cnt     <= (waiting && (state_nxt == state)) ? tmo_cnt + 1'b1 : '0;
            if (is_mv) begin
                mv_hdng <= cmd_hold[11:4];
                mv_cnt  <= cmd_hold[3:0];
                fanfare <= opcode[0];
            end
            if (is_tour) begin
                tour_x <= cmd_hold[6:4];
                tour_y <= cmd_hold[2:0];
            end
            // a tour step that lands while a response is in flight is lost
            if (tour_step && ((state == SEND) || (state == WAIT_SENT))) drop_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_kt_cmd_responder.sv
// Bench for kt_cmd_responder: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a timestamp-based behavioural model.
module tb_kt_cmd_responder;
    localparam int         TMO  = 1000;
    localparam logic [7:0] ERRB = 8'hEE;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd;
    logic        cmd_rdy, cal_done, mv_done, tour_step, tour_done, resp_sent;
    logic        clr_cmd_rdy, strt_cal, mv_go, fanfare, tour_go, send_resp, drop_err;
    logic [7:0]  mv_hdng, resp;
    logic [3:0]  mv_cnt;
    logic [2:0]  tour_x, tour_y;

    int total = 0;
    int bad   = 0;

    kt_cmd_responder #(.TMO_W(20), .TMO_CLKS(20'd1000), .RESP_ERR(ERRB)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .strt_cal(strt_cal), .cal_done(cal_done), .mv_go(mv_go), .mv_hdng(mv_hdng),
        .mv_cnt(mv_cnt), .fanfare(fanfare), .mv_done(mv_done), .tour_go(tour_go),
        .tour_x(tour_x), .tour_y(tour_y), .tour_step(tour_step), .tour_done(tour_done),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase of the current job plus the cycle the engine wait began.
    typedef enum int {PH_FREE, PH_TAKEN, PH_RUN, PH_OUT, PH_ACK} phase_t;
    phase_t      ph = PH_FREE;
    bit          mdl_on = 0;
    bit          m_more = 0;
    int          eng = 0;
    int          n = 0;
    int          t0 = 0;
    logic [15:0] held = '0;
    logic        e_clr = 0, e_cal = 0, e_mv = 0, e_tgo = 0, e_send = 0, e_fan = 0, e_drop = 0;
    logic [7:0]  e_hdng = 0, e_resp = 0;
    logic [3:0]  e_cnt = 0;
    logic [2:0]  e_tx = 0, e_ty = 0;

    task respond(input logic [7:0] v, input bit again);
        e_send = 1;
        e_resp = v;
        m_more = again;
        ph     = PH_OUT;
    endtask

    always @(posedge clk) begin
        n++;
        e_clr = 0; e_cal = 0; e_mv = 0; e_tgo = 0; e_send = 0;
        if (rst) begin
            mdl_on = 1;
            ph = PH_FREE; m_more = 0;
            e_hdng = 0; e_cnt = 0; e_fan = 0; e_tx = 0; e_ty = 0; e_resp = 0; e_drop = 0;
        end else begin
            if (tour_step && (ph == PH_OUT || ph == PH_ACK)) e_drop = 1;
            case (ph)
                PH_FREE: if (cmd_rdy) begin held = cmd; e_clr = 1; ph = PH_TAKEN; end
                PH_TAKEN: begin
                    case (held[15:12])
                        4'h0: begin e_cal = 1; eng = 0; ph = PH_RUN; t0 = n; end
                        4'h2, 4'h3: begin
                            e_mv = 1; e_hdng = held[11:4]; e_cnt = held[3:0]; e_fan = held[12];
                            eng = 1; ph = PH_RUN; t0 = n;
                        end
                        4'h4: begin
                            e_tgo = 1; e_tx = held[6:4]; e_ty = held[2:0];
                            eng = 2; ph = PH_RUN; t0 = n;
                        end
                        default: respond(ERRB, 0);
                    endcase
                end
                PH_RUN: begin
                    if ((eng == 0 && cal_done) || (eng == 1 && mv_done) || (eng == 2 && tour_done))
                        respond(8'hA5, 0);
                    else if (eng == 2 && tour_step)
                        respond(8'h5A, 1);
                    else if (n - t0 == TMO)
                        respond(ERRB, 0);
                end
                PH_OUT: ph = PH_ACK;
                PH_ACK: if (resp_sent) begin
                    if (m_more) begin ph = PH_RUN; t0 = n; end
                    else ph = PH_FREE;
                end
                default: ph = PH_FREE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            total++;
            if ({clr_cmd_rdy, strt_cal, mv_go, mv_hdng, mv_cnt, fanfare, tour_go, tour_x, tour_y,
                 resp, send_resp, drop_err} !==
                {e_clr, e_cal, e_mv, e_hdng, e_cnt, e_fan, e_tgo, e_tx, e_ty, e_resp, e_send, e_drop}) begin
                bad++;
                $display("FAIL outputs t=%0t got clr=%b cal=%b mv=%b hd=%h cnt=%h fan=%b tgo=%b x=%0d y=%0d resp=%h send=%b drop=%b want clr=%b cal=%b mv=%b hd=%h cnt=%h fan=%b tgo=%b x=%0d y=%0d resp=%h send=%b drop=%b",
                         $time, clr_cmd_rdy, strt_cal, mv_go, mv_hdng, mv_cnt, fanfare, tour_go, tour_x,
                         tour_y, resp, send_resp, drop_err, e_clr, e_cal, e_mv, e_hdng, e_cnt, e_fan,
                         e_tgo, e_tx, e_ty, e_resp, e_send, e_drop);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] c);
        cmd = c;
        cmd_rdy = 1;
        tick();
        chk("clr_cmd_rdy", 16'(clr_cmd_rdy), 16'd1);
        cmd_rdy = 0;
        tick();
    endtask

    task automatic ack();
        tick();
        resp_sent = 1;
        tick();
        resp_sent = 0;
    endtask

    logic [3:0] ops [0:6] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h1, 4'h9, 4'hF};
    int  waited;
    bit  quiet;

    initial begin
        rst = 1; cmd = 0; cmd_rdy = 0; cal_done = 0; mv_done = 0;
        tour_step = 0; tour_done = 0; resp_sent = 0;
        repeat (3) tick();
        rst = 0;
        chk("reset resp", 16'(resp), 16'h0);
        chk("reset send_resp", 16'(send_resp), 16'h0);
        chk("reset mv_hdng", 16'(mv_hdng), 16'h0);
        chk("reset drop_err", 16'(drop_err), 16'h0);
        tick();

        issue(16'h0000);
        chk("cal strt_cal", 16'(strt_cal), 16'd1);
        chk("cal mv_go", 16'(mv_go), 16'd0);
        cal_done = 1; tick(); cal_done = 0;
        chk("cal send_resp", 16'(send_resp), 16'd1);
        chk("cal resp", 16'(resp), 16'h00A5);
        chk("model cal resp", 16'(e_resp), 16'h00A5);
        ack();

        issue(16'h23F2);
        chk("mv1 mv_go", 16'(mv_go), 16'd1);
        chk("mv1 hdng", 16'(mv_hdng), 16'h003F);
        chk("mv1 cnt", 16'(mv_cnt), 16'd2);
        chk("mv1 fanfare", 16'(fanfare), 16'd0);
        mv_done = 1; tick(); mv_done = 0;
        chk("mv1 resp", {7'd0, send_resp, resp}, 16'h01A5);
        ack();

        issue(16'h37F1);
        chk("mv2 fanfare", 16'(fanfare), 16'd1);
        chk("mv2 hdng", 16'(mv_hdng), 16'h007F);
        chk("mv2 cnt", 16'(mv_cnt), 16'd1);
        chk("model mv2 hdng", 16'(e_hdng), 16'h007F);
        mv_done = 1; tick(); mv_done = 0;
        chk("mv2 resp", {7'd0, send_resp, resp}, 16'h01A5);
        ack();

        issue(16'h4022);
        chk("tour go", 16'(tour_go), 16'd1);
        chk("tour xy", {10'd0, tour_x, tour_y}, 16'h0012);
        for (int i = 0; i < 2; i++) begin
            tour_step = 1; tick(); tour_step = 0;
            chk("tour step resp", {7'd0, send_resp, resp}, 16'h015A);
            ack();
        end
        tour_done = 1; tick(); tour_done = 0;
        chk("tour done resp", {7'd0, send_resp, resp}, 16'h01A5);
        ack();

        issue(16'h9000);
        chk("bad op resp", {7'd0, send_resp, resp}, 16'h01EE);
        chk("bad op no go", {13'd0, strt_cal, mv_go, tour_go}, 16'd0);
        ack();

        issue(16'h2001);
        chk("tmo mv_go", 16'(mv_go), 16'd1);
        waited = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (send_resp) begin waited = i; break; end
        end
        chk("timeout cycles", 16'(waited), 16'd1000);
        chk("timeout resp", 16'(resp), 16'h00EE);
        ack();

        issue(16'h2AB5);
        chk("pre-rst hdng", 16'(mv_hdng), 16'h00AB);
        repeat (3) tick();
        rst = 1; tick(); rst = 0;
        chk("rst hdng", 16'(mv_hdng), 16'h0);
        chk("rst cnt", 16'(mv_cnt), 16'h0);
        chk("rst resp", 16'(resp), 16'h0);
        tick();
        issue(16'h0000);
        chk("post-rst strt_cal", 16'(strt_cal), 16'd1);
        cal_done = 1; tick(); cal_done = 0;
        chk("post-rst resp", 16'(resp), 16'h00A5);
        tick();
        tour_step = 1; tick(); tour_step = 0;
        chk("drop_err set", 16'(drop_err), 16'd1);
        resp_sent = 1; tick(); resp_sent = 0;

        for (int c = 0; c < 8000; c++) begin
            quiet = (c >= 1500 && c < 2800) || (c >= 5000 && c < 6300);
            tick();
            if (cmd_rdy) begin
                if (clr_cmd_rdy) cmd_rdy = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                cmd = {ops[$urandom_range(0, 6)], 12'($urandom)};
                cmd_rdy = 1;
            end
            cal_done  = !quiet && ($urandom_range(0, 19) == 0);
            mv_done   = !quiet && ($urandom_range(0, 19) == 0);
            tour_step = !quiet && ($urandom_range(0, 14) == 0);
            tour_done = !quiet && ($urandom_range(0, 39) == 0);
            resp_sent = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 599) == 0);
        end
        tick();
        rst = 0; cmd_rdy = 0; cal_done = 0; mv_done = 0;
        tour_step = 0; tour_done = 0; resp_sent = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
